// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_pkg
// Description : Shared FSM state encoding and wait-counter width for the
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Wide enough for WAIT_STATES in 0..15
    localparam int c_WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_array
// Description : Single-port word storage, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array
    import mem_responder_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 i_wrEn,
    input  logic                 i_rdEn,
    input  logic [ADDR_BITS-1:0] i_adr,
    input  logic [WIDTH-1:0]     i_wrData,
    output logic [WIDTH-1:0]     o_rdData
);

    // Contents deliberately have no reset so they survive a responder reset
    logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_adr] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_adr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Wait-stated memory responder: accept, count, access, respond.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqValid,
    input  logic             reqWrite,
    input  logic [WIDTH-1:0] adrToMem,
    input  logic [WIDTH-1:0] dataToMem,
    output logic             reqReady,
    output logic [WIDTH-1:0] dataFromMem,
    output logic             respValid,
    output logic             respErr
);

    state_t                    r_state;
    state_t                    w_nextState;
    logic [c_WAIT_CNT_W-1:0]   r_waitCnt;
    logic                      r_write;
    logic [WIDTH-1:0]          r_adr;
    logic [WIDTH-1:0]          r_wrData;
    logic                      r_rdZero;
    logic                      w_accept;
    logic                      w_access;
    logic                      w_outOfRange;
    logic                      w_ramWrEn;
    logic                      w_ramRdEn;
    logic [WIDTH+ADDR_BITS-1:0] w_adrExt;
    logic [WIDTH-1:0]          w_ramRdData;

    // Zero-extension keeps the range test legal whatever WIDTH vs ADDR_BITS
    assign w_adrExt     = {{ADDR_BITS{1'b0}}, r_adr};
    assign w_outOfRange = (w_adrExt >> ADDR_BITS) != '0;

    always_comb begin
        w_nextState = r_state;
        reqReady    = 1'b0;
        respValid   = 1'b0;
        respErr     = 1'b0;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    w_accept    = 1'b1;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (r_waitCnt == '0) begin
                    w_access    = 1'b1;
                    w_nextState = RESP;
                end
            end
            RESP: begin
                respValid   = 1'b1;
                respErr     = w_outOfRange;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt <= '0;
            r_write   <= 1'b0;
            r_adr     <= '0;
            r_wrData  <= '0;
            r_rdZero  <= 1'b1;
        end else begin
            if (w_accept) begin
                r_waitCnt <= c_WAIT_CNT_W'(WAIT_STATES);
                r_write   <= reqWrite;
                r_adr     <= adrToMem;
                r_wrData  <= dataToMem;
            end else if (r_state == BUSY && r_waitCnt != '0) begin
                r_waitCnt <= r_waitCnt - c_WAIT_CNT_W'(1);
            end
            // Out-of-range reads return zero while the RAM read register holds
            if (w_access && !r_write) begin
                r_rdZero <= w_outOfRange;
            end
        end
    end

    assign w_ramWrEn   = w_access && r_write && !w_outOfRange;
    assign w_ramRdEn   = w_access && !r_write && !w_outOfRange;
    assign dataFromMem = r_rdZero ? '0 : w_ramRdData;

    ram_array #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk      (clk),
        .i_wrEn   (w_ramWrEn),
        .i_rdEn   (w_ramRdEn),
        .i_adr    (w_adrExt[ADDR_BITS-1:0]),
        .i_wrData (r_wrData),
        .o_rdData (w_ramRdData)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder (2 and 0 waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_reqValid, a_reqWrite, a_reqReady, a_respValid, a_respErr;
    logic [15:0] a_adr, a_wdata, a_rdata;
    logic        b_reqValid, b_reqWrite, b_reqReady, b_respValid, b_respErr;
    logic [15:0] b_adr, b_wdata, b_rdata;
    int          errors    = 0;
    int          checks    = 0;
    int          respCntA  = 0;

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .reqValid(a_reqValid), .reqWrite(a_reqWrite),
        .adrToMem(a_adr), .dataToMem(a_wdata), .reqReady(a_reqReady),
        .dataFromMem(a_rdata), .respValid(a_respValid), .respErr(a_respErr)
    );

    mem_responder #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .reqValid(b_reqValid), .reqWrite(b_reqWrite),
        .adrToMem(b_adr), .dataToMem(b_wdata), .reqReady(b_reqReady),
        .dataFromMem(b_rdata), .respValid(b_respValid), .respErr(b_respErr)
    );

    always @(posedge clk) begin
        if (a_respValid === 1'b1) respCntA++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_reqReady : b_reqReady;
    endfunction
    function automatic logic rv(input int sel);
        return (sel == 0) ? a_respValid : b_respValid;
    endfunction
    function automatic logic rerr(input int sel);
        return (sel == 0) ? a_respErr : b_respErr;
    endfunction
    function automatic logic [15:0] rdat(input int sel);
        return (sel == 0) ? a_rdata : b_rdata;
    endfunction

    // One full transaction; latency counts negedges from the drive point to respValid
    task automatic access(input int sel, input logic wr, input logic [15:0] adr,
                          input logic [15:0] wd, input logic [15:0] expData,
                          input logic expErr, input string tag);
        int n;
        int lat;
        n = 0;
        while (rdy(sel) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, rdy(sel), 1'b1);
        if (sel == 0) begin
            a_reqValid = 1'b1; a_reqWrite = wr; a_adr = adr; a_wdata = wd;
        end else begin
            b_reqValid = 1'b1; b_reqWrite = wr; b_adr = adr; b_wdata = wd;
        end
        @(negedge clk);
        a_reqValid = 1'b0;
        b_reqValid = 1'b0;
        lat = 1;
        while (rv(sel) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (sel == 0) ? 4 : 2);
        check({tag, "_data"}, rdat(sel), expData);
        check({tag, "_err"}, rerr(sel), expErr);
        @(negedge clk);
        check({tag, "_pulse_end"}, rv(sel), 1'b0);
        check({tag, "_ready_back"}, rdy(sel), 1'b1);
    endtask

    logic [15:0] expq[$];
    int          cntSnap;
    int          lastAcc;
    int          nAcc;
    int          nResp;
    logic        accLast;

    initial begin
        reset = 1'b0;
        a_reqValid = 1'b0; a_reqWrite = 1'b0; a_adr = '0; a_wdata = '0;
        b_reqValid = 1'b0; b_reqWrite = 1'b0; b_adr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", a_reqReady, 1'b1);
        check("rst_respValid", a_respValid, 1'b0);
        check("rst_respErr", a_respErr, 1'b0);
        check("rst_data", a_rdata, 16'h0000);
        check("rst_ready0", b_reqReady, 1'b1);
        check("rst_data0", b_rdata, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        // Write then read back the same word
        cntSnap = respCntA;
        access(0, 1'b1, 16'd5, 16'h1234, 16'h0000, 1'b0, "wr5");
        access(0, 1'b0, 16'd5, 16'h0000, 16'h1234, 1'b0, "rd5");
        check("two_pulses", respCntA - cntSnap, 2);

        // Exact cycle timing: accept at edge 0, respValid only after edge 3
        check("t_ready_pre", a_reqReady, 1'b1);
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_adr = 16'd5;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            a_reqValid = 1'b0;
            check("t_respValid", a_respValid, (e == 3));
            check("t_reqReady", a_reqReady, (e == 4));
            if (e == 3) check("t_data", a_rdata, 16'h1234);
        end

        // Range boundary and aliasing of out-of-range addresses
        access(0, 1'b1, 16'h0000, 16'h0BAD, 16'h1234, 1'b0, "wr0");
        access(0, 1'b1, 16'h03FF, 16'h0FFF, 16'h1234, 1'b0, "wr3ff");
        access(0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1, "rd400");
        access(0, 1'b1, 16'h0400, 16'hBEEF, 16'h0000, 1'b1, "wr400");
        access(0, 1'b1, 16'h8005, 16'hDEAD, 16'h0000, 1'b1, "wr8005");
        access(0, 1'b0, 16'h0000, 16'h0000, 16'h0BAD, 1'b0, "rd0_kept");
        access(0, 1'b0, 16'h03FF, 16'h0000, 16'h0FFF, 1'b0, "rd3ff_kept");
        access(0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, "rd5_kept");

        // Continuous requests alternating addresses 1 and 2
        access(0, 1'b1, 16'd1, 16'h1111, 16'h1234, 1'b0, "wr1");
        access(0, 1'b1, 16'd2, 16'h2222, 16'h1234, 1'b0, "wr2");
        a_reqValid = 1'b1; a_reqWrite = 1'b0; a_adr = 16'd1;
        accLast = 1'b0; lastAcc = -1; nAcc = 0; nResp = 0;
        expq.delete();
        for (int i = 0; i < 20; i++) begin
            if (a_respValid === 1'b1) begin
                nResp++;
                check("stream_has_pending", (expq.size() > 0), 1'b1);
                if (expq.size() > 0) check("stream_data", a_rdata, expq.pop_front());
            end
            if (accLast) a_adr = (a_adr == 16'd1) ? 16'd2 : 16'd1;
            accLast = 1'b0;
            if (a_reqReady === 1'b1) begin
                // Accept-to-accept: BUSY (W+1) + RESP + IDLE = 5 edges
                if (lastAcc >= 0) check("stream_spacing", i - lastAcc, 5);
                lastAcc = i;
                nAcc++;
                expq.push_back((a_adr == 16'd1) ? 16'h1111 : 16'h2222);
                accLast = 1'b1;
            end
            @(negedge clk);
        end
        a_reqValid = 1'b0;
        check("stream_accepts", nAcc, 4);
        check("stream_resps", nResp, 4);
        check("stream_drained", expq.size(), 0);

        // Reset in the middle of a write leaves storage untouched
        access(0, 1'b1, 16'd7, 16'h5555, 16'h2222, 1'b0, "wr7");
        cntSnap = respCntA;
        a_reqValid = 1'b1; a_reqWrite = 1'b1; a_adr = 16'd7; a_wdata = 16'hAAAA;
        @(negedge clk);
        a_reqValid = 1'b0;
        check("abort_busy", a_reqReady, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rst_ready", a_reqReady, 1'b1);
        check("abort_rst_respValid", a_respValid, 1'b0);
        check("abort_rst_respErr", a_respErr, 1'b0);
        check("abort_rst_data", a_rdata, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_resp", respCntA - cntSnap, 0);
        access(0, 1'b0, 16'd7, 16'h0000, 16'h5555, 1'b0, "rd7_after_abort");

        // Zero wait states: read / write / read back-to-back
        access(1, 1'b1, 16'd9, 16'h0101, 16'h0000, 1'b0, "z_wr9");
        access(1, 1'b0, 16'd9, 16'h0000, 16'h0101, 1'b0, "z_rd9");
        access(1, 1'b1, 16'd9, 16'hCAFE, 16'h0101, 1'b0, "z_wr9b");
        access(1, 1'b0, 16'd9, 16'h0000, 16'hCAFE, 1'b0, "z_rd9b");
        access(1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, "z_rd_oor");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
